bq_resp_frame_rx: RTL and testbench
===================================

Name: bq_resp_frame_rx

Overview:
- Receive-side framer for BQ79606 response frames. It sits between the UART byte receiver and the host register interface.
- It takes byte strobes from the UART RX and parses the frame: header, device address, 16-bit register address, 1..128 data bytes, then a 2-byte CRC.
- It drives the team's CRC16_CHK checker, instantiated inside this block, and streams the payload bytes out.
- It ends each frame with a one-cycle completion pulse carrying an OK flag and an error code.

Parameters:
- TIMEOUT_CYC, 20000: number of sclk cycles without a byte inside a frame before the frame is aborted.
- CNT_W, 15: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- sclk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rx_data  in  8  received byte from the UART, LSB-first already assembled
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle
- rx_err  in  1  one-cycle UART framing or parity error strobe
- dev_addr  out  8  device address of the last frame; held until the next frame_done
- reg_addr  out  16  register address of the last frame, first byte is MSB; held
- data_len  out  8  payload length 1..128; held
- data_out  out  8  payload byte
- data_valid  out  1  one-cycle strobe per payload byte
- data_idx  out  7  index of the payload byte, 0-based
- frame_done  out  1  one-cycle frame completion or abort pulse
- frame_ok  out  1  valid with frame_done: 1 means the CRC residue is zero and no error occurred
- err_code  out  2  valid with frame_done: 00 none, 01 CRC, 10 timeout, 11 UART error

Behaviour:
- Reset: clock is sclk; reset is synchronous and active-low. While reset=0:
  - state goes to IDLE; the timeout counter clears;
  - all outputs are 0; the CRC checker is held in reset by the inverted reset.
- States: IDLE, DEV, RA_H, RA_L, DATA, CRC_L, CRC_H, CHECK.
- A byte is accepted only when rx_valid=1.
- IDLE:
  - Header byte with bit7=0: data_len = hdr[6:0]+1, go to DEV.
  - Header byte with bit7=1 (command frame): discarded, stay in IDLE, no frame_done.
- Field states:
  - DEV latches dev_addr, then RA_H.
  - RA_H latches reg_addr[15:8], then RA_L.
  - RA_L latches reg_addr[7:0], then DATA.
- DATA:
  - Each accepted byte gives data_out/data_valid registered one cycle after rx_valid. data_idx counts 0..data_len-1.
  - After the byte with index data_len-1, go to CRC_L.
- CRC: CRC_L then CRC_H accept the CRC low byte then the high byte; after CRC_H go to CHECK.
- CRC feed:
  - Every accepted byte from header through CRC_H drives crc_din=rx_data and crc_en=1 in the same cycle.
  - CRC is CRC-16 with polynomial 0x8005, reflected, init 0xFFFF. A good frame leaves a zero residue.
- Checker init:
  - init=1 in IDLE when rx_valid=0, in CHECK, and in any abort cycle.
  - Because of this, the first header byte always sees 0xFFFF.
- CHECK (exactly one cycle, one cycle after the last CRC byte):
  - crc_chk_en=1; the checker's crc_err is sampled.
  - Next cycle: frame_done=1, frame_ok=~crc_err, err_code=01 if crc_err else 00. State returns to IDLE.
  - An rx_valid arriving in CHECK is ignored; UART byte spacing is ≥10 bit times.
- Latency: frame_done is asserted 2 sclk cycles after rx_valid of the CRC high byte.
- Timeout:
  - In any state other than IDLE or CHECK, the counter increments every cycle and clears on each accepted byte.
  - When it reaches TIMEOUT_CYC: abort with frame_done=1, frame_ok=0, err_code=10, then IDLE.
- UART error:
  - rx_err=1 outside IDLE: abort with err_code=11, then IDLE.
  - rx_err in IDLE is ignored.
  - If rx_err and rx_valid occur in the same cycle, rx_err wins and the byte is discarded.
- Abort rules:
  - Payload bytes already streamed are not recalled; downstream logic must discard them when frame_ok=0.
  - dev_addr, reg_addr and data_len keep the values of the aborted frame.
- Reset mid-frame: immediate return to IDLE with no frame_done pulse.

Decomposition:
- Package bq_uart_pkg holds:
  - state enum;
  - err_code constants ERR_NONE, ERR_CRC, ERR_TMO, ERR_UART;
  - RESP_HDR_BIT=7;
  - CRC_RESIDUE=16'h0000.
- One sub-module: the existing CRC16_CHK checker, instantiated with reset tied to ~reset. No other sub-modules.

Test Plan:
- Good frame: hdr 0x01 (2 bytes), dev 0x05, reg 0x01 0x23, data 0xAA 0x55, CRC from a model (0x8005 reflected, init 0xFFFF), low byte first.
  -> data_valid twice with idx 0,1; dev_addr=0x05, reg_addr=0x0123, data_len=2; frame_done 2 cycles after the CRC high byte; frame_ok=1, err_code=00.
- Same frame with data byte 0x55 replaced by 0x54 -> frame_done, frame_ok=0, err_code=01. The next good frame passes, proving the checker re-inits.
- Frame stopped after RA_L with no further bytes -> frame_done exactly TIMEOUT_CYC cycles after the last byte; err_code=10; state returns to IDLE.
- rx_err pulse during DATA; then a header byte 0x80 in IDLE -> abort with err_code=11; the 0x80 byte is ignored with no frame_done.
- Max-length frame, hdr 0x7F (128 bytes) -> data_idx reaches 127, then CRC is accepted and frame_ok=1.
- Back-to-back good frames with 1 idle cycle between them, plus reset=0 asserted mid-DATA -> no frame_done for the reset frame; the subsequent frame gives frame_ok=1.

Source files
------------

// File: rtl/bq_uart_pkg.sv
// Shared definitions for the BQ79606 response-frame receiver.
//   state_e      : receive FSM states
//   ERR_*        : completion error codes carried with frame_done
//   RESP_HDR_BIT : header bit that marks a command frame (1) versus a response frame (0)
//   CRC_RESIDUE  : checker value left behind by a frame whose CRC bytes are correct
//   crc16_update : one byte of CRC-16, polynomial 0x8005 in reflected form
package bq_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDev,
        StRaH,
        StRaL,
        StData,
        StCrcL,
        StCrcH,
        StCheck
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CRC  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_UART = 2'b11;

    localparam int unsigned RESP_HDR_BIT = 7;

    localparam logic [15:0] CRC_RESIDUE   = 16'h0000;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    // 0x8005 bit-reversed, for the LSB-first shift
    localparam logic [15:0] CRC_POLY_REFL = 16'hA001;

    function automatic logic [15:0] crc16_update(logic [15:0] crc, logic [7:0] din);
        logic [15:0] c;
        c = crc ^ {8'h00, din};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/CRC16_CHK.sv
// CRC16_CHK: byte-wise CRC-16 checker (poly 0x8005 reflected, init 0xFFFF).
// Feeding a whole frame including its trailing CRC (low byte first) leaves a zero residue.
// Ports:
//   clk        in  clock
//   reset      in  synchronous, active-high reset; loads the init value
//   init       in  reload the init value next cycle (takes priority over crc_en)
//   crc_en     in  fold crc_din into the running CRC
//   crc_din    in  byte to fold
//   crc_chk_en in  compare the running CRC against the expected residue
//   crc_err    out 1 when crc_chk_en=1 and the residue is not zero
module CRC16_CHK
    import bq_uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic       crc_en,
    input  logic [7:0] crc_din,
    input  logic       crc_chk_en,
    output logic       crc_err
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC_INIT;
        end else if (crc_en) begin
            crc_d = crc16_update(crc_q, crc_din);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_err = crc_chk_en && (crc_q != CRC_RESIDUE);

endmodule

// File: rtl/bq_resp_frame_rx.sv
// bq_resp_frame_rx: receive-side framer for BQ79606 response frames.
// Parses header, device address, 16-bit register address, 1..128 payload bytes and a
// 2-byte CRC from UART byte strobes, streams the payload and reports each frame with a
// one-cycle completion pulse.
// Ports:
//   sclk       in  system clock
//   reset      in  synchronous, active-low reset
//   rx_data    in  received byte
//   rx_valid   in  rx_data strobe
//   rx_err     in  UART framing/parity error strobe
//   dev_addr   out device address of the last frame (held)
//   reg_addr   out register address of the last frame, MSB byte first on the wire (held)
//   data_len   out payload length 1..128 (held)
//   data_out   out payload byte
//   data_valid out one-cycle strobe per payload byte
//   data_idx   out 0-based payload byte index
//   frame_done out one-cycle completion or abort pulse
//   frame_ok   out with frame_done: zero CRC residue and no error
//   err_code   out with frame_done: 00 none, 01 CRC, 10 timeout, 11 UART
module bq_resp_frame_rx
    import bq_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 20000,
    parameter int unsigned CNT_W       = 15
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_err,
    output logic [7:0]  dev_addr,
    output logic [15:0] reg_addr,
    output logic [7:0]  data_len,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [6:0]  data_idx,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [1:0]  err_code
);

    // The abort decision is registered into frame_done, so firing one count early puts the
    // pulse exactly TIMEOUT_CYC cycles after the strobe of the last accepted byte.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]  idx_q, idx_d;
    logic [7:0]  dev_q, dev_d;
    logic [15:0] ra_q, ra_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  dout_q, dout_d;
    logic        dval_q, dval_d;
    logic [6:0]  didx_q, didx_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic [1:0]  err_q, err_d;

    logic        accept;
    logic        uart_abort;
    logic        tmo_hit;
    logic [7:0]  len_m1;

    logic        crc_rst;
    logic        crc_init;
    logic        crc_en;
    logic [7:0]  crc_din;
    logic        crc_chk_en;
    logic        crc_err;

    // rx_err wins over a byte strobed in the same cycle
    assign accept     = rx_valid && !rx_err;
    assign uart_abort = rx_err && (state_q != StIdle);
    assign tmo_hit    = (state_q != StIdle) && (state_q != StCheck) && !accept &&
                        (cnt_q == TMO_LAST);
    assign len_m1     = len_q - 8'd1;

    // Kept outside the FSM block so crc_err -> crc_chk_en is not seen as a loop
    assign crc_chk_en = (state_q == StCheck);
    assign crc_rst    = ~reset;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        dev_d    = dev_q;
        ra_d     = ra_q;
        len_d    = len_q;
        dout_d   = dout_q;
        dval_d   = 1'b0;
        didx_d   = didx_q;
        done_d   = 1'b0;
        ok_d     = 1'b0;
        err_d    = ERR_NONE;
        crc_init = 1'b0;
        crc_en   = 1'b0;
        crc_din  = rx_data;

        if ((state_q == StIdle) || (state_q == StCheck) || accept) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (uart_abort) begin
            state_d  = StIdle;
            done_d   = 1'b1;
            err_d    = ERR_UART;
            crc_init = 1'b1;
            cnt_d    = '0;
        end else if (tmo_hit) begin
            state_d  = StIdle;
            done_d   = 1'b1;
            err_d    = ERR_TMO;
            crc_init = 1'b1;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Command frames (bit7=1) are dropped without touching the CRC
                    if (accept && !rx_data[RESP_HDR_BIT]) begin
                        len_d   = {1'b0, rx_data[6:0]} + 8'd1;
                        idx_d   = '0;
                        crc_en  = 1'b1;
                        state_d = StDev;
                    end else begin
                        crc_init = 1'b1;
                    end
                end
                StDev: begin
                    if (accept) begin
                        dev_d   = rx_data;
                        crc_en  = 1'b1;
                        state_d = StRaH;
                    end
                end
                StRaH: begin
                    if (accept) begin
                        ra_d[15:8] = rx_data;
                        crc_en     = 1'b1;
                        state_d    = StRaL;
                    end
                end
                StRaL: begin
                    if (accept) begin
                        ra_d[7:0] = rx_data;
                        crc_en    = 1'b1;
                        state_d   = StData;
                    end
                end
                StData: begin
                    if (accept) begin
                        crc_en = 1'b1;
                        dout_d = rx_data;
                        dval_d = 1'b1;
                        didx_d = idx_q;
                        idx_d  = idx_q + 7'd1;
                        if ({1'b0, idx_q} == len_m1) begin
                            state_d = StCrcL;
                        end
                    end
                end
                StCrcL: begin
                    if (accept) begin
                        crc_en  = 1'b1;
                        state_d = StCrcH;
                    end
                end
                StCrcH: begin
                    if (accept) begin
                        crc_en  = 1'b1;
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    // One-cycle verdict; any byte strobed here is ignored
                    crc_init = 1'b1;
                    done_d   = 1'b1;
                    ok_d     = ~crc_err;
                    err_d    = crc_err ? ERR_CRC : ERR_NONE;
                    state_d  = StIdle;
                end
                default: begin
                    state_d  = StIdle;
                    crc_init = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            dev_q   <= '0;
            ra_q    <= '0;
            len_q   <= '0;
            dout_q  <= '0;
            dval_q  <= 1'b0;
            didx_q  <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dev_q   <= dev_d;
            ra_q    <= ra_d;
            len_q   <= len_d;
            dout_q  <= dout_d;
            dval_q  <= dval_d;
            didx_q  <= didx_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    CRC16_CHK u_crc (
        .clk        (sclk),
        .reset      (crc_rst),
        .init       (crc_init),
        .crc_en     (crc_en),
        .crc_din    (crc_din),
        .crc_chk_en (crc_chk_en),
        .crc_err    (crc_err)
    );

    assign dev_addr   = dev_q;
    assign reg_addr   = ra_q;
    assign data_len   = len_q;
    assign data_out   = dout_q;
    assign data_valid = dval_q;
    assign data_idx   = didx_q;
    assign frame_done = done_q;
    assign frame_ok   = ok_q;
    assign err_code   = err_q;

endmodule

// File: tb/tb_bq_resp_frame_rx.sv
// Bench for bq_resp_frame_rx: frame-level model (byte list -> expected payload stream and
// completion events) checked every cycle by one compare process, plus literal pins.
module tb_bq_resp_frame_rx;

    localparam int unsigned TMO = 200;

    logic        sclk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_err = 1'b0;
    logic [7:0]  dev_addr;
    logic [15:0] reg_addr;
    logic [7:0]  data_len;
    logic [7:0]  data_out;
    logic        data_valid;
    logic [6:0]  data_idx;
    logic        frame_done;
    logic        frame_ok;
    logic [1:0]  err_code;

    bq_resp_frame_rx #(
        .TIMEOUT_CYC (TMO),
        .CNT_W       (8)
    ) dut (
        .sclk       (sclk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .dev_addr   (dev_addr),
        .reg_addr   (reg_addr),
        .data_len   (data_len),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_idx   (data_idx),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .err_code   (err_code)
    );

    always #5 sclk = ~sclk;

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        bit          ok;
        logic [1:0]  err;
        logic [7:0]  dev;
        logic [15:0] ra;
        logic [7:0]  len;
    } done_t;

    done_t       exp_done[$];
    logic [14:0] exp_data[$];   // {idx, byte}
    logic [7:0]  tx_q[$];
    logic [7:0]  pl_q[$];
    int          s;
    int          last_s;

    // Reference CRC-16 (0x8005 reflected, init 0xFFFF), one message bit at a time
    function automatic logic [15:0] crc_of_tx();
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (tx_q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ tx_q[i][b];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic build(input logic [7:0] hdr, input logic [7:0] dev, input logic [15:0] ra);
        logic [15:0] c;
        tx_q.delete();
        tx_q.push_back(hdr);
        tx_q.push_back(dev);
        tx_q.push_back(ra[15:8]);
        tx_q.push_back(ra[7:0]);
        foreach (pl_q[i]) tx_q.push_back(pl_q[i]);
        c = crc_of_tx();
        tx_q.push_back(c[7:0]);
        tx_q.push_back(c[15:8]);
    endtask

    task automatic fill_payload(input int n, input int seed);
        pl_q.delete();
        for (int i = 0; i < n; i++) pl_q.push_back(8'((seed + i * 37) & 8'hFF));
    endtask

    task automatic push_done(input int c, input bit ok, input logic [1:0] err);
        done_t d;
        d.cyc = c;
        d.ok  = ok;
        d.err = err;
        d.dev = tx_q[1];
        d.ra  = {tx_q[2], tx_q[3]};
        d.len = {1'b0, tx_q[0][6:0]} + 8'd1;
        exp_done.push_back(d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit err, output int strobe);
        @(posedge sclk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        rx_err   = err;
        strobe   = cyc;
        @(posedge sclk);
        #1;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
    endtask

    // Sends tx_q[lo..hi]; payload bytes in that range are expected on the stream.
    // When complete=1 the frame verdict follows from the CRC of the whole byte list.
    task automatic send_frame(input int lo, input int hi, input bit complete);
        int len;
        bit ok;
        len = int'(tx_q[0][6:0]) + 1;
        for (int i = lo; i <= hi; i++) begin
            if (i >= 4 && i < 4 + len) exp_data.push_back({7'(i - 4), tx_q[i]});
            send_byte(tx_q[i], 1'b0, s);
            last_s = s;
        end
        if (complete) begin
            ok = (crc_of_tx() == 16'h0000);
            push_done(last_s + 2, ok, ok ? 2'b00 : 2'b01);
        end
    endtask

    logic [14:0] ce;
    done_t       cd;

    always @(negedge sclk) begin
        if (data_valid) begin
            if (exp_data.size() == 0) begin
                check("unexpected_data_valid", data_valid, 1'b0);
            end else begin
                ce = exp_data.pop_front();
                check("data_out", data_out, ce[7:0]);
                check("data_idx", data_idx, ce[14:8]);
            end
        end
        if (frame_done) begin
            if (exp_done.size() == 0) begin
                check("unexpected_frame_done", frame_done, 1'b0);
            end else begin
                cd = exp_done.pop_front();
                check("done_cycle", cyc, cd.cyc);
                check("frame_ok", frame_ok, cd.ok);
                check("err_code", err_code, cd.err);
                check("dev_addr", dev_addr, cd.dev);
                check("reg_addr", reg_addr, cd.ra);
                check("data_len", data_len, cd.len);
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        check(name, {dev_addr, reg_addr, data_len, data_out},
              {8'h00, 16'h0000, 8'h00, 8'h00});
        check({name, "_ctl"}, {data_valid, data_idx, frame_done, frame_ok, err_code}, 12'h000);
    endtask

    initial begin
        // Model pins against published CRC-16/MODBUS values
        tx_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        check("model_pin_123456789", crc_of_tx(), 16'h4B37);
        tx_q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        check("model_pin_modbus_req", crc_of_tx(), 16'h0A84);

        reset = 1'b0;
        idle(3);
        @(negedge sclk);
        check_reset_outputs("reset_state");
        @(posedge sclk);
        #1;
        reset = 1'b1;
        idle(2);

        // Good 2-byte frame
        pl_q = '{8'hAA, 8'h55};
        build(8'h01, 8'h05, 16'h0123);
        check("model_good_residue", crc_of_tx(), 16'h0000);
        send_frame(0, 7, 1'b1);
        idle(4);
        check("lit_dev_addr", dev_addr, 8'h05);
        check("lit_reg_addr", reg_addr, 16'h0123);
        check("lit_data_len", data_len, 8'h02);

        // Corrupted payload byte, then the good frame again
        tx_q[5] = 8'h54;
        check("model_bad_residue_nonzero", crc_of_tx() != 16'h0000, 1'b1);
        send_frame(0, 7, 1'b1);
        idle(2);
        pl_q = '{8'hAA, 8'h55};
        build(8'h01, 8'h05, 16'h0123);
        send_frame(0, 7, 1'b1);
        idle(3);

        // Timeout after RA_L
        fill_payload(3, 9);
        build(8'h02, 8'h11, 16'h4002);
        send_frame(0, 3, 1'b0);
        push_done(last_s + TMO, 1'b0, 2'b10);
        idle(TMO + 5);
        fill_payload(1, 77);
        build(8'h00, 8'h12, 16'h0304);
        send_frame(0, 6, 1'b1);
        idle(3);

        // UART error together with a DATA byte, then a command header and a lone rx_err
        fill_payload(4, 200);
        build(8'h03, 8'h22, 16'h1000);
        send_frame(0, 5, 1'b0);
        send_byte(tx_q[6], 1'b1, s);
        push_done(s + 1, 1'b0, 2'b11);
        idle(2);
        send_byte(8'h80, 1'b0, s);
        idle(3);
        @(posedge sclk);
        #1;
        rx_err = 1'b1;
        @(posedge sclk);
        #1;
        rx_err = 1'b0;
        idle(3);
        check("lit_dev_after_abort", dev_addr, 8'h22);
        fill_payload(2, 5);
        build(8'h01, 8'h33, 16'hBEEF);
        send_frame(0, 7, 1'b1);
        idle(3);

        // Maximum length frame
        fill_payload(128, 3);
        build(8'h7F, 8'h3C, 16'h5A5A);
        send_frame(0, 133, 1'b1);
        idle(4);
        check("lit_max_len", data_len, 8'h80);

        // Back-to-back frames with one idle cycle between them
        fill_payload(2, 40);
        build(8'h01, 8'h06, 16'h0707);
        send_frame(0, 7, 1'b1);
        fill_payload(1, 90);
        build(8'h00, 8'h07, 16'h0808);
        send_frame(0, 6, 1'b1);
        idle(3);

        // Reset in the middle of DATA: no completion for that frame
        fill_payload(4, 120);
        build(8'h03, 8'h44, 16'h0A0B);
        send_frame(0, 5, 1'b0);
        idle(1);
        reset = 1'b0;
        @(posedge sclk);
        @(negedge sclk);
        check_reset_outputs("reset_mid_frame");
        @(posedge sclk);
        #1;
        reset = 1'b1;
        idle(2);
        fill_payload(3, 60);
        build(8'h02, 8'h45, 16'h0C0D);
        send_frame(0, 8, 1'b1);
        idle(10);

        check("pending_data", exp_data.size(), 0);
        check("pending_done", exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
